// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - requester IDs and default widths for the writeback arbiter
package regfile_wb_arbiter_pkg;

  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 64;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rtl/regfile_wb_arbiter_rr_arb2.sv - two-way round-robin arbiter, pointer moves only on a grant
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == REQ_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // A grant is always a transfer because ready is the grant itself.
  always_comb begin
    last_d = last_q;
    if (gnt[0])      last_d = REQ_EXU;
    else if (gnt[1]) last_d = REQ_LSU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_LSU;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - EXU/LSU writeback arbiter with busy scoreboard
// Optional trace printing of writes and grant conflicts: define REGFILE_WB_TRACE_EN.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] dataD
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [1:0]            req, gnt;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  // Masking requests with rst_n keeps both readies low during reset.
  assign req = {lsu_valid & rst_n, exu_valid & rst_n};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign exu_ready = gnt[0];
  assign lsu_ready = gnt[1];
  assign xfer      = |gnt;
  assign sel_rd    = gnt[1] ? lsu_rd   : exu_rd;
  assign sel_data  = gnt[1] ? lsu_data : exu_data;

  always_comb begin
    wen_d   = xfer && (sel_rd != '0);
    rd_d    = xfer ? sel_rd   : rd_q;
    wdata_d = xfer ? sel_data : wdata_q;
  end

  // Clear first, then set, so an issue at the same edge as a retire wins.
  always_comb begin
    busy_d = busy_q;
    if (xfer)        busy_d[sel_rd]   = 1'b0;
    if (issue_valid) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign wen      = wen_q;
  assign rd       = rd_q;
  assign dataD    = wdata_q;
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

`ifdef REGFILE_WB_TRACE_EN
  always @(posedge clk) begin
    if (rst_n && xfer && (sel_rd != '0))
      $display("wb x%0d <- 0x%0h (%s)", sel_rd, sel_data, gnt[1] ? "lsu" : "exu");
    if (rst_n && exu_valid && lsu_valid)
      $display("wb conflict: exu and lsu both valid, grant %s", gnt[1] ? "lsu" : "exu");
  end
`else
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_valid, lsu_valid, issue_valid;
  logic        exu_ready, lsu_ready, rs1_busy, rs2_busy, wen;
  logic [4:0]  exu_rd, lsu_rd, issue_rd, rs1, rs2, rd;
  logic [63:0] exu_data, lsu_data, dataD;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_rd      (exu_rd),
    .exu_data    (exu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .wen         (wen),
    .rd          (rd),
    .dataD       (dataD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_gnt [4];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;

    rst_n = 1'b1;
    exu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
    exu_rd = '0; lsu_rd = '0; issue_rd = '0; rs1 = '0; rs2 = '0;
    exu_data = '0; lsu_data = '0;
    #3 rst_n = 1'b0;

    // reset state, readies held low even with a valid request
    next_cycle();
    exu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    check("rst_exu_ready", exu_ready, 0);
    check("rst_lsu_ready", lsu_ready, 0);
    check("rst_wen", wen, 0);
    check("rst_rd", rd, 0);
    check("rst_dataD", dataD, 0);
    next_cycle();
    check("rst_wen_after_edge", wen, 0);
    exu_valid = 1'b0; lsu_valid = 1'b0;
    rst_n = 1'b1;

    // round-robin tie after reset: EXU, LSU, EXU, LSU
    next_cycle();
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 64'hA3;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'hB4;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d_exu_ready", i), exu_ready, exp_gnt[i][0]);
      check($sformatf("rr%0d_lsu_ready", i), lsu_ready, exp_gnt[i][1]);
      if (i > 0) begin
        check($sformatf("rr%0d_wen", i), wen, 1);
        check($sformatf("rr%0d_rd", i), rd, exp_gnt[i-1][1] ? 5'd4 : 5'd3);
      end
      next_cycle();
    end
    check("rr_last_wen", wen, 1);
    check("rr_last_rd", rd, 4);
    check("rr_last_dataD", dataD, 64'hB4);
    exu_valid = 1'b0; lsu_valid = 1'b0;

    // single EXU write to a non-busy register
    next_cycle();
    check("idle_wen", wen, 0);
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 64'h1234; rs1 = 5'd5;
    #1;
    check("exu_ready", exu_ready, 1);
    check("exu_lsu_ready", lsu_ready, 0);
    next_cycle();
    exu_valid = 1'b0;
    check("exu_wen", wen, 1);
    check("exu_rd", rd, 5);
    check("exu_dataD", dataD, 64'h1234);
    check("exu_nonbusy_rs1", rs1_busy, 0);
    next_cycle();
    check("exu_wen_drop", wen, 0);
    check("exu_rd_hold", rd, 5);
    check("exu_dataD_hold", dataD, 64'h1234);

    // issue marks busy, LSU retire clears it
    issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
    #1;
    check("busy7_no_bypass", rs1_busy, 0);
    next_cycle();
    issue_valid = 1'b0;
    check("busy7_set", rs1_busy, 1);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h77;
    #1;
    check("busy7_lsu_ready", lsu_ready, 1);
    check("busy7_still_set", rs1_busy, 1);
    next_cycle();
    lsu_valid = 1'b0;
    check("busy7_cleared", rs1_busy, 0);
    check("busy7_wen", wen, 1);
    check("busy7_rd", rd, 7);

    // same-edge issue and retire of x9 leaves it busy
    issue_valid = 1'b1; issue_rd = 5'd9; rs2 = 5'd9;
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 64'h99;
    next_cycle();
    issue_valid = 1'b0; exu_valid = 1'b0;
    check("busy9_kept", rs2_busy, 1);
    check("busy9_wen", wen, 1);
    check("busy9_rd", rd, 9);

    // x0 write accepted but suppressed, x0 never busy
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 64'hFFFF; rs1 = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    check("x0_exu_ready", exu_ready, 1);
    next_cycle();
    exu_valid = 1'b0; issue_valid = 1'b0;
    check("x0_wen", wen, 0);
    check("x0_rs1_busy", rs1_busy, 0);

    // reset between transfer and write cycle; last grant was EXU so tie goes to LSU
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 64'hA3;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'hB4;
    issue_valid = 1'b1; issue_rd = 5'd12; rs1 = 5'd12;
    #1;
    check("pre_rst_lsu_ready", lsu_ready, 1);
    check("pre_rst_exu_ready", exu_ready, 0);
    next_cycle();
    issue_valid = 1'b0;
    check("pre_rst_busy12", rs1_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen", wen, 0);
    check("mid_rst_rd", rd, 0);
    check("mid_rst_dataD", dataD, 0);
    check("mid_rst_busy12", rs1_busy, 0);
    check("mid_rst_busy9", rs2_busy, 0);
    check("mid_rst_lsu_ready", lsu_ready, 0);
    next_cycle();
    check("mid_rst_wen_hold", wen, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_exu_ready", exu_ready, 1);
    check("post_rst_lsu_ready", lsu_ready, 0);
    next_cycle();
    exu_valid = 1'b0; lsu_valid = 1'b0;
    check("post_rst_wen", wen, 1);
    check("post_rst_rd", rd, 3);
    check("post_rst_dataD", dataD, 64'hA3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports exu_valid/exu_ready  input/output  1/1  EXU writeback handshake.
REQ-006 SHALL have ports exu_rd/exu_data  input  ADDR_WIDTH/DATA_WIDTH  EXU destination and value.
REQ-007 SHALL have ports lsu_valid/lsu_ready  input/output  1/1  LSU writeback handshake.
REQ-008 SHALL have ports lsu_rd/lsu_data  input  ADDR_WIDTH/DATA_WIDTH  LSU destination and value.
REQ-009 SHALL have ports issue_valid/issue_rd  input  1/ADDR_WIDTH  marks a destination register pending at issue.
REQ-010 SHALL have ports rs1/rs2  input  ADDR_WIDTH  hazard query indices.
REQ-011 SHALL have ports rs1_busy/rs2_busy  output  1  query index has a pending write.
REQ-012 SHALL have ports wen/rd/dataD  output  1/ADDR_WIDTH/DATA_WIDTH  drive the register file write port.

Function
REQ-013 A transfer SHALL occur on a requester when valid and ready are both high at a rising edge.
REQ-014 ready SHALL be combinational: at most one of exu_ready/lsu_ready high per cycle, only for a valid requester.
REQ-015 Arbitration SHALL be round-robin; a single valid requester is always granted; with both valid, grant goes to the one not granted last.
REQ-016 Last-grant pointer SHALL update only on a transfer; reset value points to LSU so EXU wins the first tie.
REQ-017 Write-port outputs SHALL be registered: transfer at edge N -> wen=1, rd, dataD valid during cycle N+1 for exactly one cycle.
REQ-018 No transfer at edge N -> wen=0 in cycle N+1; rd/dataD hold prior values.
REQ-019 Transfer with rd=0 SHALL be accepted but SHALL produce wen=0.
REQ-020 Scoreboard SHALL hold one busy bit per register, 2^ADDR_WIDTH entries; entry 0 is constant 0.
REQ-021 issue_valid at edge SHALL set busy[issue_rd]; a transfer SHALL clear busy[transfer rd].
REQ-022 Simultaneous set and clear of the same index SHALL leave it set (newer issue wins).
REQ-023 rs1_busy/rs2_busy SHALL be combinational reads of the registered busy bits, no same-cycle bypass.
REQ-024 A transfer to a non-busy index SHALL be accepted and written normally; the busy bit stays 0.

Reset
REQ-025 rst_n low SHALL asynchronously clear all busy bits, wen, rd, dataD to 0 and set last-grant to LSU.
REQ-026 Reset mid-transfer SHALL drop the in-flight write; wen=0 until a new transfer after release.
REQ-027 exu_ready/lsu_ready SHALL be 0 while rst_n is low.

Configuration
REQ-028 Macro REGFILE_WB_TRACE_EN defined: SHALL $display each write as "wb x<rd> <- 0x<data> (exu|lsu)" and each grant conflict.
REQ-029 Macro REGFILE_WB_TRACE_EN undefined: no display code SHALL be compiled; function identical.

Structure
REQ-030 Shared package SHALL hold requester-ID enum (REQ_EXU, REQ_LSU) and default ADDR_WIDTH/DATA_WIDTH constants.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arb2 (two requests, grant vector, pointer update on transfer).
REQ-032 Outputs wen/rd/dataD SHALL connect unmodified to register_file wen/rd/dataD.

Verification
REQ-033 EXU only, exu_rd=5, data=0x1234 -> exu_ready=1 same cycle; next cycle wen=1, rd=5, dataD=0x1234; then wen=0.
REQ-034 Both valid for 4 cycles after reset, rds 3 (EXU) and 4 (LSU) -> grants EXU,LSU,EXU,LSU; writes follow one cycle later.
REQ-035 issue_rd=7, then rs1=7 -> rs1_busy=1 next cycle; LSU transfer rd=7 -> rs1_busy=0 the cycle after.
REQ-036 issue_rd=9 and EXU transfer rd=9 at same edge -> busy[9] stays 1.
REQ-037 EXU transfer rd=0 data=0xFFFF -> exu_ready=1, next cycle wen=0; rs1=0 -> rs1_busy=0.
REQ-038 rst_n low between transfer and write cycle -> wen=0, all busy cleared; first tie after release granted to EXU.
